pipelined_cla_adder: RTL

//  Parametrised, pipelined carry-look-ahead adder/subtractor for the datapath arithmetic library.

---
 rtl/pipelined_cla_adder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined carry-look-ahead adder/subtractor, one CLA group per stage
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready is combinational: !out_valid || out_ready)
//   a, b, cin, sub        operands; sub=1 computes a - b - cin
//   out_valid / out_ready output handshake with backpressure
//   sum, cout, ovf        word-aligned result, MSB carry-out, signed overflow
`timescale 1ns/1ps
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / GROUP;

    if ((WIDTH % GROUP) != 0 || WIDTH < GROUP) begin : g_bad_params
        $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of GROUP");
    end

    // One look-ahead group: every internal carry is a flat sum of products of
    // generate/propagate terms and the group carry-in, so no ripple inside the group.
    // Returns {carry_out, sum}.
    function automatic logic [GROUP:0] cla_group(
        input logic [GROUP-1:0] x,
        input logic [GROUP-1:0] y,
        input logic             ci
    );
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic             acc;
        logic             pp;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < GROUP; i++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & ci);
        end
        return {c[GROUP], p ^ c[GROUP-1:0]};
    endfunction

    logic             adv;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

    // Stall everything whenever a result is waiting and nobody takes it.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Subtraction is folded in up front: invert b and flip the carry.
    // Data is zeroed on idle cycles so bubbles carry no stray operand values.
    assign a_in = in_valid ? a : '0;
    assign b_in = in_valid ? (b ^ {WIDTH{sub}}) : '0;
    assign c_in = in_valid & (cin ^ sub);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still unconsumed after this stage.
        localparam int REM = WIDTH - (k + 1) * GROUP;

        logic [REM+GROUP-1:0]     op_a;    // operands arriving at this stage
        logic [REM+GROUP-1:0]     op_b;
        logic                     op_c;    // carry into this stage's group
        logic                     op_v;
        logic [k*GROUP+GROUP-1:0] s_next;
        logic [GROUP-1:0]         gs;
        logic                     gco;

        logic                     v;
        logic                     c;
        logic [k*GROUP+GROUP-1:0] s;

        if (k == 0) begin : g_src
            assign op_a   = a_in;
            assign op_b   = b_in;
            assign op_c   = c_in;
            assign op_v   = in_valid;
            assign s_next = gs;
        end else begin : g_src
            assign op_a   = g_stage[k-1].g_ops.ra;
            assign op_b   = g_stage[k-1].g_ops.rb;
            assign op_c   = g_stage[k-1].c;
            assign op_v   = g_stage[k-1].v;
            assign s_next = {gs, g_stage[k-1].s};
        end

        assign {gco, gs} = cla_group(op_a[GROUP-1:0], op_b[GROUP-1:0], op_c);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v <= 1'b0;
                c <= 1'b0;
                s <= '0;
            end else if (adv) begin
                v <= op_v;
                c <= gco;
                s <= s_next;
            end
        end

        // Skew registers: only the operand bits later stages still need.
        if (REM > 0) begin : g_ops
            logic [REM-1:0] ra;
            logic [REM-1:0] rb;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ra <= '0;
                    rb <= '0;
                end else if (adv) begin
                    ra <= op_a[REM+GROUP-1:GROUP];
                    rb <= op_b[REM+GROUP-1:GROUP];
                end
            end
        end

        // Signed overflow: both addends share a sign that the sum does not.
        // Equivalent to (carry into MSB) ^ (carry out of MSB).
        if (k == STAGES - 1) begin : g_last
            logic o;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    o <= 1'b0;
                end else if (adv) begin
                    o <= (op_a[GROUP-1] == op_b[GROUP-1]) && (gs[GROUP-1] != op_a[GROUP-1]);
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v;
    assign sum       = g_stage[STAGES-1].s;
    assign cout      = g_stage[STAGES-1].c;
    assign ovf       = g_stage[STAGES-1].g_last.o;

endmodule
